// File: rtl/triangle_pkg.sv
// Shared types for the triangle stream analyzer and any matching generator.
// Optional feature macro: TRIANGLE_ANALYZER_STATS_EN (adds error_count).
package triangle_pkg;

    // Tracker states: wait for first sample, find direction, then follow slope
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        UP      = 2'd2,
        DOWN    = 2'd3
    } state_t;

    localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/triangle_analyzer_if.sv
// Sample stream and status bundle between a triangle source and the analyzer.
// Optional feature macro: TRIANGLE_ANALYZER_STATS_EN (adds error_count).
interface triangle_analyzer_if
    import triangle_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned PW = N + 1
);
    logic          ena;
    logic [N-1:0]  in;
    logic          dir;
    logic          locked;
    logic          peak;
    logic          valley;
    logic          error;
    logic [PW-1:0] period;
    logic          period_valid;
`ifdef TRIANGLE_ANALYZER_STATS_EN
    logic [ERR_CNT_W-1:0] error_count;

    modport master (output ena, in,
                    input  dir, locked, peak, valley, error, period, period_valid, error_count);
    modport slave  (input  ena, in,
                    output dir, locked, peak, valley, error, period, period_valid, error_count);
`else
    modport master (output ena, in,
                    input  dir, locked, peak, valley, error, period, period_valid);
    modport slave  (input  ena, in,
                    output dir, locked, peak, valley, error, period, period_valid);
`endif
endinterface

// File: rtl/triangle_analyzer_sat_counter.sv
// Saturating up-counter; clr wins, and clr with inc restarts the count at 1.
module sat_counter #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register: clear/restart, else saturating increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/triangle_analyzer.sv
// Tracks a 0..MAX..0 triangle sample stream: direction, turn pulses,
// illegal-step errors and the valley-to-valley period.
// Optional feature macro: TRIANGLE_ANALYZER_STATS_EN (adds error_count).
module triangle_analyzer
    import triangle_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned PW = N + 1
) (
    input logic                clk,
    input logic                rst,
    triangle_analyzer_if.slave bus
);

    localparam int unsigned NX     = N + 1;
    localparam logic [N-1:0] MAX    = {N{1'b1}};
    localparam logic [N-1:0] MAX_M1 = MAX - N'(1);

    state_t        state_q, state_d;
    logic [N-1:0]  prev_q, prev_d;
    logic          dir_q, dir_d;
    logic          locked_q, locked_d;
    logic          have_valley_q, have_valley_d;
    logic          peak_q, peak_d;
    logic          valley_q, valley_d;
    logic          err_q, err_d;
    logic [PW-1:0] period_q, period_d;
    logic          pv_q, pv_d;
    logic [PW-1:0] cnt;
    logic          cnt_clr, cnt_inc;

    // Steps compared one bit wider so MAX->0 and 0->MAX never look legal
    logic [NX-1:0] in_x, up_x, dn_x;
    assign in_x = {1'b0, bus.in};
    assign up_x = {1'b0, prev_q} + NX'(1);
    assign dn_x = {1'b0, prev_q} - NX'(1);

    // Next-state, step classification and status updates
    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        locked_d      = locked_q;
        have_valley_d = have_valley_q;
        period_d      = period_q;
        peak_d        = 1'b0;
        valley_d      = 1'b0;
        err_d         = 1'b0;
        pv_d          = 1'b0;
        if (bus.ena) begin
            prev_d = bus.in;
            unique case (state_q)
                IDLE: state_d = ACQUIRE;
                ACQUIRE: begin
                    if (in_x == up_x)      state_d = UP;
                    else if (in_x == dn_x) state_d = DOWN;
                    else                   err_d   = 1'b1;
                end
                UP: begin
                    if (in_x == up_x) begin
                        state_d = UP;
                    end else if ((prev_q == MAX) && (bus.in == MAX_M1)) begin
                        state_d = DOWN;
                        peak_d  = 1'b1;
                    end else begin
                        state_d = ACQUIRE;
                        err_d   = 1'b1;
                    end
                end
                DOWN: begin
                    if (in_x == dn_x) begin
                        state_d = DOWN;
                    end else if ((prev_q == '0) && (bus.in == N'(1))) begin
                        state_d  = UP;
                        valley_d = 1'b1;
                    end else begin
                        state_d = ACQUIRE;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (err_d) begin
            locked_d      = 1'b0;
            have_valley_d = 1'b0;
        end
        if (valley_d) begin
            have_valley_d = 1'b1;
            if (have_valley_q) begin
                period_d = cnt;
                pv_d     = 1'b1;
                locked_d = 1'b1;
            end
        end
        dir_d   = (state_d == DOWN);
        cnt_clr = err_d | valley_d;
        cnt_inc = bus.ena & ~err_d;
    end

    // State, history and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            prev_q        <= '0;
            dir_q         <= 1'b0;
            locked_q      <= 1'b0;
            have_valley_q <= 1'b0;
            peak_q        <= 1'b0;
            valley_q      <= 1'b0;
            err_q         <= 1'b0;
            period_q      <= '0;
            pv_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            dir_q         <= dir_d;
            locked_q      <= locked_d;
            have_valley_q <= have_valley_d;
            peak_q        <= peak_d;
            valley_q      <= valley_d;
            err_q         <= err_d;
            period_q      <= period_d;
            pv_q          <= pv_d;
        end
    end

    sat_counter #(.W(PW)) u_period_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (cnt)
    );

    assign bus.dir          = dir_q;
    assign bus.locked       = locked_q;
    assign bus.peak         = peak_q;
    assign bus.valley       = valley_q;
    assign bus.error        = err_q;
    assign bus.period       = period_q;
    assign bus.period_valid = pv_q;

`ifdef TRIANGLE_ANALYZER_STATS_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Saturating count of illegal steps since reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign bus.error_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_triangle_analyzer.sv
// Directed bench for triangle_analyzer at N=4 (MAX=15, nominal period 30).
module tb_triangle_analyzer;
    import triangle_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    triangle_analyzer_if #(.N(4), .PW(5)) bus ();
    triangle_analyzer #(.N(4), .PW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ena;
        logic [3:0] smp;
        logic       err;
        logic       peak;
        logic       valley;
        logic       dir;
        state_t     st;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, then land 1 time unit after the capturing edge
    task automatic apply(input logic e, input logic [3:0] v);
        bus.ena = e;
        bus.in  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        bus.ena = 1'b0;
        bus.in  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " dir"}, int'(bus.dir), 0);
        chk({tag, " locked"}, int'(bus.locked), 0);
        chk({tag, " peak"}, int'(bus.peak), 0);
        chk({tag, " valley"}, int'(bus.valley), 0);
        chk({tag, " error"}, int'(bus.error), 0);
        chk({tag, " period"}, int'(bus.period), 0);
        chk({tag, " pvalid"}, int'(bus.period_valid), 0);
        chk({tag, " state"}, int'(dut.state_q), int'(IDLE));
    endtask

    function automatic logic [3:0] tri_at(input int k);
        int p;
        p = k % 30;
        return (p <= 15) ? 4'(p) : 4'(30 - p);
    endfunction

    // Ideal generator stream from reset; optionally interleave ena=0 junk cycles
    task automatic run_stream(input bit toggle, input int last_k);
        int  k;
        int  kl;
        int  cyc;
        bit  e;
        k   = 0;
        kl  = -1;
        cyc = 0;
        while (k <= last_k) begin
            e = !toggle || (cyc % 2 == 0);
            if (e) begin
                apply(1'b1, tri_at(k));
                kl = k;
                k++;
            end else begin
                apply(1'b0, 4'($urandom_range(0, 15)));
            end
            chk($sformatf("s%0d k%0d error", toggle, kl), int'(bus.error), 0);
            chk($sformatf("s%0d k%0d peak", toggle, kl), int'(bus.peak),
                int'(e && (kl == 16 || kl == 46 || kl == 76 || kl == 106)));
            chk($sformatf("s%0d k%0d valley", toggle, kl), int'(bus.valley),
                int'(e && (kl == 31 || kl == 61 || kl == 91)));
            chk($sformatf("s%0d k%0d pvalid", toggle, kl), int'(bus.period_valid),
                int'(e && (kl == 61 || kl == 91)));
            chk($sformatf("s%0d k%0d locked", toggle, kl), int'(bus.locked), int'(kl >= 61));
            chk($sformatf("s%0d k%0d period", toggle, kl), int'(bus.period), (kl >= 61) ? 30 : 0);
            chk($sformatf("s%0d k%0d dir", toggle, kl), int'(bus.dir),
                int'(kl >= 16 && ((kl - 16) % 30) < 15));
            cyc++;
        end
    endtask

    vec_t tbl [32];

    initial begin
        n_vec = 0;
        n_bad = 0;
        tbl = '{
            '{1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0, ACQUIRE},
            '{1'b1, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0, UP},
            '{1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0, UP},
            '{1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, UP},
            '{1'b1, 4'd14, 1'b0, 1'b1, 1'b0, 1'b1, DOWN},
            '{1'b1, 4'd13, 1'b0, 1'b0, 1'b0, 1'b1, DOWN},
            '{1'b1, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE},
            '{1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, UP},
            '{1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE},
            '{1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, UP},
            '{1'b0, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0, UP},
            '{1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0, UP},
            '{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0, UP},
            '{1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 1'b0, UP},
            '{1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, UP},
            '{1'b1, 4'd7,  1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE},
            '{1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, UP},
            '{1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0, UP},
            '{1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, UP},
            '{1'b1, 4'd9,  1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE},
            '{1'b1, 4'd9,  1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE},
            '{1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 1'b1, DOWN},
            '{1'b1, 4'd8,  1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE},
            '{1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, DOWN},
            '{1'b1, 4'd6,  1'b0, 1'b0, 1'b0, 1'b1, DOWN},
            '{1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE},
            '{1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE},
            '{1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE},
            '{1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE},
            '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, DOWN},
            '{1'b1, 4'd1,  1'b0, 1'b0, 1'b1, 1'b0, UP},
            '{1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE}
        };

        do_reset();
        chk_all_zero("reset");

        // Directed step table: errors, turns, wrap attempts, ena hold
        for (int i = 0; i < 32; i++) begin
            apply(tbl[i].ena, tbl[i].smp);
            chk($sformatf("t%0d error", i), int'(bus.error), int'(tbl[i].err));
            chk($sformatf("t%0d peak", i), int'(bus.peak), int'(tbl[i].peak));
            chk($sformatf("t%0d valley", i), int'(bus.valley), int'(tbl[i].valley));
            chk($sformatf("t%0d dir", i), int'(bus.dir), int'(tbl[i].dir));
            chk($sformatf("t%0d state", i), int'(dut.state_q), int'(tbl[i].st));
            chk($sformatf("t%0d locked", i), int'(bus.locked), 0);
            chk($sformatf("t%0d pvalid", i), int'(bus.period_valid), 0);
            chk($sformatf("t%0d period", i), int'(bus.period), 0);
        end

        // Clean stream from reset, ending DOWN and locked
        do_reset();
        run_stream(1'b0, 110);
        chk("pre-reset state", int'(dut.state_q), int'(DOWN));

        // Asynchronous reset mid-stream, observed before the next edge
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async rst");
        #1;
        rst = 1'b1;
        apply(1'b1, 4'd5);
        chk("reacq state", int'(dut.state_q), int'(ACQUIRE));
        chk("reacq error", int'(bus.error), 0);
        apply(1'b1, 4'd6);
        chk("reacq up state", int'(dut.state_q), int'(UP));
        chk("reacq locked", int'(bus.locked), 0);
        chk("reacq period", int'(bus.period), 0);

        // Same stream with ena toggling every cycle
        do_reset();
        run_stream(1'b1, 95);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/triangle_analyzer.md
TRIANGLE_ANALYZER -- requirements
Module: triangle_analyzer

Interface
REQ-001 SHALL have parameter N, default 8, giving the sample width; the peak value MAX = 2^N-1.
REQ-002 SHALL have parameter PW, default N+1, giving the period width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous assertion, active-low.
REQ-005 ena  input  1  sample qualifier; `in` is consumed only when ena=1.
REQ-006 in  input  N  sample stream from a triangle source: 0,1,..,MAX,MAX-1,..,0,1,..
REQ-007 dir  output  1  current direction: 0=up, 1=down.
REQ-008 locked  output  1  stream verified across at least one full period.
REQ-009 peak  output  1  one-cycle pulse on a valid turn at MAX.
REQ-010 valley  output  1  one-cycle pulse on a valid turn at 0.
REQ-011 error  output  1  one-cycle pulse on an illegal step.
REQ-012 period  output  PW  samples between the last two valleys; held between updates.
REQ-013 period_valid  output  1  one-cycle pulse when `period` updates.

Function
REQ-014 SHALL register all outputs; each pulse appears in the cycle after the clk edge that consumed the causing sample.
REQ-015 SHALL have FSM states IDLE, ACQUIRE, UP, DOWN, and SHALL keep a registered previous sample `prev`.
REQ-016 SHALL, with ena=0, hold all state and registers, with pulses driven 0.
REQ-017 SHALL, in IDLE on a sample: store prev and go to ACQUIRE.
REQ-018 SHALL, in ACQUIRE: in==prev+1 -> UP; in==prev-1 -> DOWN; otherwise pulse error and stay in ACQUIRE; prev is updated in every case.
REQ-019 SHALL, in UP: in==prev+1 stays UP; prev==MAX and in==MAX-1 -> DOWN with a peak pulse; anything else pulses error and goes to ACQUIRE.
REQ-020 SHALL, in DOWN: in==prev-1 stays DOWN; prev==0 and in==1 -> UP with a valley pulse; anything else pulses error and goes to ACQUIRE.
REQ-021 SHALL evaluate prev+1 and prev-1 at N+1 bits, so MAX->0 and 0->MAX are illegal steps and do not wrap.
REQ-022 SHALL treat a repeated sample (in==prev) as an error.
REQ-023 SHALL have a period counter that increments per consumed sample, saturates at 2^PW-1, and restarts at 1 on each valley.
REQ-024 SHALL, on a valley with a prior valley recorded since the last error: load period, pulse period_valid, and set locked. The nominal period is 2*MAX.
REQ-025 SHALL, on error: clear locked, clear the prior-valley flag and the period counter; `period` keeps its last value.
REQ-026 SHALL drive dir=1 in DOWN and dir=0 otherwise.

Reset
REQ-027 SHALL, while rst=0, asynchronously force: state=IDLE, prev=0, counter=0, period=0, and all other outputs 0.
REQ-028 SHALL, on reset mid-stream, discard history; reacquisition restarts from IDLE.

Configuration
REQ-029 SHALL, with macro TRIANGLE_ANALYZER_STATS_EN defined, add output error_count (8 bits): increments on each error, saturates at 255, cleared by reset.
REQ-030 SHALL, without TRIANGLE_ANALYZER_STATS_EN, omit the error_count port and its logic entirely; all other behaviour is identical.

Structure
REQ-031 SHALL place the state_t enum (IDLE, ACQUIRE, UP, DOWN) in shared package triangle_pkg, usable by the generator side.
REQ-032 SHALL implement the saturating period counter as sub-module sat_counter (parameter W; ports clr, inc, count).

Verification (N=4, MAX=15)
REQ-033 A generator-driven stream with ena=1 from reset: first valley gives valley=1 only; second valley gives period=30, period_valid=1, locked=1.
REQ-034 The same stream with ena toggled every cycle: period=30, and pulses appear only after ena=1 edges.
REQ-035 Inject 5,7 while UP: error=1, locked=0, state ACQUIRE; on the next 8, state UP with no second error.
REQ-036 Sequences 10,9 in UP and 15,0 in UP: each produces error=1 and no peak.
REQ-037 Sequence 14,15,14: peak=1, dir goes 0->1, error=0.
REQ-038 Drop rst during DOWN while locked: all outputs 0 before the next clk edge; state IDLE after release.
